tengigeth_loop_axis_demux: RTL and testbench

- Frame-aware 1:2 AXI-Stream demultiplexer on the 10GbE loopback path; the splitting counterpart of the 2:1 loopback stream mux.
- Takes one 64-bit stream and steers each whole frame to output 0 or output 1.
- The route is sampled from mux_select on the first beat of each frame and held until tlast. Changing mux_select mid-frame can never split a frame.
- Each output is fully registered through a 2-entry skid buffer, so no combinational path runs from output tready to input tready.

---
 rtl/tengigeth_loop_axis_demux_pkg.sv | 17 +
 rtl/tengigeth_loop_axis_skid.sv | 94 +++++++++
 rtl/tengigeth_loop_axis_demux.sv | 108 ++++++++++
 tb/tb_tengigeth_loop_axis_demux.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tengigeth_loop_axis_demux_pkg.sv
// rtl/tengigeth_loop_axis_demux_pkg.sv - shared types and widths for the loopback stream demux
package tengigeth_loop_axis_demux_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD0 = 2'd1,
        ST_FWD1 = 2'd2
    } state_e;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/tengigeth_loop_axis_skid.sv
// rtl/tengigeth_loop_axis_skid.sv - 2-entry registered AXIS slice (main + skid) carrying data/keep/last
module tengigeth_loop_axis_skid
    import tengigeth_loop_axis_demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEEP_WIDTH = keep_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
    input  logic                  s_tlast_i,
    input  logic                  s_push_i,
    output logic                  s_full_o,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_tkeep_o,
    output logic                  m_tlast_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i
);

    logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [KEEP_WIDTH-1:0] main_keep_q, main_keep_d, skid_keep_q, skid_keep_d;
    logic                  main_last_q, main_last_d, skid_last_q, skid_last_d;
    logic                  main_valid_q, main_valid_d, skid_full_q, skid_full_d;
    logic                  drain;

    // The producer only pushes while the skid is empty, so a push never collides with a skid refill.
    always_comb begin
        main_data_d  = main_data_q;
        main_keep_d  = main_keep_q;
        main_last_d  = main_last_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        skid_full_d  = skid_full_q;
        drain        = main_valid_q & m_tready_i;

        if (drain) begin
            if (skid_full_q) begin
                main_data_d = skid_data_q;
                main_keep_d = skid_keep_q;
                main_last_d = skid_last_q;
                skid_full_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end

        if (s_push_i) begin
            if (!main_valid_q || drain) begin
                main_data_d  = s_tdata_i;
                main_keep_d  = s_tkeep_i;
                main_last_d  = s_tlast_i;
                main_valid_d = 1'b1;
            end else begin
                skid_data_d = s_tdata_i;
                skid_keep_d = s_tkeep_i;
                skid_last_d = s_tlast_i;
                skid_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_q  <= '0;
            main_keep_q  <= '0;
            main_last_q  <= 1'b0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_full_q  <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_keep_q  <= main_keep_d;
            main_last_q  <= main_last_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
            skid_full_q  <= skid_full_d;
        end
    end

    assign s_full_o   = skid_full_q;
    assign m_tdata_o  = main_data_q;
    assign m_tkeep_o  = main_keep_q;
    assign m_tlast_o  = main_last_q;
    assign m_tvalid_o = main_valid_q;

endmodule

// File: rtl/tengigeth_loop_axis_demux.sv
// rtl/tengigeth_loop_axis_demux.sv - frame-aware 1:2 AXIS demux with per-output skid buffers and frame counters
module tengigeth_loop_axis_demux
    import tengigeth_loop_axis_demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEEP_WIDTH = keep_width(DATA_WIDTH),
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mux_select,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic [KEEP_WIDTH-1:0] tkeep,
    input  logic                  tvalid,
    input  logic                  tlast,
    output logic                  tready,
    output logic [DATA_WIDTH-1:0] tdata0,
    output logic [KEEP_WIDTH-1:0] tkeep0,
    output logic                  tvalid0,
    output logic                  tlast0,
    input  logic                  tready0,
    output logic [DATA_WIDTH-1:0] tdata1,
    output logic [KEEP_WIDTH-1:0] tkeep1,
    output logic                  tvalid1,
    output logic                  tlast1,
    input  logic                  tready1,
    output logic [CNT_WIDTH-1:0]  frm_cnt0,
    output logic [CNT_WIDTH-1:0]  frm_cnt1,
    output logic                  busy
);

    state_e               state_q, state_d;
    logic                 ready_en_q;
    logic                 tgt;
    logic                 accept;
    logic [1:0]           full;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Route follows mux_select only between frames; mid-frame it is pinned by the state.
    assign tgt    = (state_q == ST_IDLE) ? mux_select : (state_q == ST_FWD1);
    assign tready = ready_en_q & ~full[tgt];
    assign accept = tvalid & tready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:          if (accept && !tlast) state_d = tgt ? ST_FWD1 : ST_FWD0;
            ST_FWD0, ST_FWD1: if (accept && tlast)  state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (tvalid0 && tready0 && tlast0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_WIDTH'(1);
        if (tvalid1 && tready1 && tlast1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    tengigeth_loop_axis_skid #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) u_skid0 (
        .clk        (clk),
        .rst        (rst),
        .s_tdata_i  (tdata),
        .s_tkeep_i  (tkeep),
        .s_tlast_i  (tlast),
        .s_push_i   (accept & ~tgt),
        .s_full_o   (full[0]),
        .m_tdata_o  (tdata0),
        .m_tkeep_o  (tkeep0),
        .m_tlast_o  (tlast0),
        .m_tvalid_o (tvalid0),
        .m_tready_i (tready0)
    );

    tengigeth_loop_axis_skid #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) u_skid1 (
        .clk        (clk),
        .rst        (rst),
        .s_tdata_i  (tdata),
        .s_tkeep_i  (tkeep),
        .s_tlast_i  (tlast),
        .s_push_i   (accept & tgt),
        .s_full_o   (full[1]),
        .m_tdata_o  (tdata1),
        .m_tkeep_o  (tkeep1),
        .m_tlast_o  (tlast1),
        .m_tvalid_o (tvalid1),
        .m_tready_i (tready1)
    );

    assign frm_cnt0 = cnt0_q;
    assign frm_cnt1 = cnt1_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tengigeth_loop_axis_demux.sv
// tb/tb_tengigeth_loop_axis_demux.sv - self-checking bench for the loopback stream demux
module tb_tengigeth_loop_axis_demux;

    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mux_select;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid, tlast, tready;
    logic [DW-1:0] tdata0, tdata1;
    logic [KW-1:0] tkeep0, tkeep1;
    logic          tvalid0, tlast0, tready0, tvalid1, tlast1, tready1;
    logic [CW-1:0] frm_cnt0, frm_cnt1;
    logic          busy;

    always #5 clk = ~clk;

    tengigeth_loop_axis_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .mux_select(mux_select),
        .tdata(tdata), .tkeep(tkeep), .tvalid(tvalid), .tlast(tlast), .tready(tready),
        .tdata0(tdata0), .tkeep0(tkeep0), .tvalid0(tvalid0), .tlast0(tlast0), .tready0(tready0),
        .tdata1(tdata1), .tkeep1(tkeep1), .tvalid1(tvalid1), .tlast1(tlast1), .tready1(tready1),
        .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1), .busy(busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        bit sel;
        int len;
        bit tog;
        bit gap;
        int c0;
        int c1;
    } vec_t;

    beat_t q0[$];
    beat_t q1[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    bit    in_frame = 0;
    bit    route = 0;
    bit    en = 0;
    int    mc0 = 0;
    int    mc1 = 0;
    bit    rand_rdy = 0;
    int    fid = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each output is a FIFO of accepted-but-undelivered beats; a frame's route is latched at its first beat.
    always @(negedge clk) begin : model
        beat_t b;
        bit    t;
        if (rst) begin
            q0.delete();
            q1.delete();
            in_frame = 0;
            en = 0;
            mc0 = 0;
            mc1 = 0;
            chk("rst_tvalid0", tvalid0, 0);
            chk("rst_tvalid1", tvalid1, 0);
            chk("rst_tready", tready, 0);
        end else begin
            t = in_frame ? route : mux_select;
            chk("tready", tready, en && ((t ? q1.size() : q0.size()) < 2));
            chk("busy", busy, in_frame);
            chk("frm_cnt0", frm_cnt0, mc0);
            chk("frm_cnt1", frm_cnt1, mc1);
            chk("tvalid0", tvalid0, q0.size() != 0);
            chk("tvalid1", tvalid1, q1.size() != 0);
            if (tvalid0 && q0.size() != 0) begin
                chk("tdata0", tdata0, q0[0].d);
                chk("tkeep0", tkeep0, q0[0].k);
                chk("tlast0", tlast0, q0[0].l);
            end
            if (tvalid1 && q1.size() != 0) begin
                chk("tdata1", tdata1, q1[0].d);
                chk("tkeep1", tkeep1, q1[0].k);
                chk("tlast1", tlast1, q1[0].l);
            end
            if (tvalid0 && tready0 && q0.size() != 0) begin
                if (q0[0].l && mc0 < CMAX) mc0++;
                void'(q0.pop_front());
            end
            if (tvalid1 && tready1 && q1.size() != 0) begin
                if (q1[0].l && mc1 < CMAX) mc1++;
                void'(q1.pop_front());
            end
            if (tvalid && tready) begin
                b = '{d: tdata, k: tkeep, l: tlast};
                if (t) q1.push_back(b);
                else   q0.push_back(b);
                if (tlast) in_frame = 0;
                else if (!in_frame) begin
                    in_frame = 1;
                    route = t;
                end
            end
            en = 1;
        end
    end

    initial begin : rdy_gen
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) begin
                tready0 = ($urandom_range(0, 3) != 0);
                tready1 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input bit tog, output int waits);
        bit acc;
        acc = 0;
        waits = 0;
        tvalid = 1'b1;
        tdata = d;
        tkeep = k;
        tlast = l;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk);
            #1;
            if (tog) mux_select = ~mux_select;
            if (!acc) waits++;
        end
        if (!acc) chk("accept_timeout", acc, 1);
    endtask

    task automatic send_frame(input bit sel, input int len, input bit tog, input bit gap,
                              input bit rnd, output int waits);
        int            w;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        waits = 0;
        mux_select = sel;
        for (int i = 0; i < len; i++) begin
            d = rnd ? {$urandom, $urandom} : {fid[31:0], i[31:0]};
            k = rnd ? KW'($urandom_range(0, 255)) : ((i == len - 1) ? 8'h0F : 8'hFF);
            send_beat(d, k, i == len - 1, tog, w);
            waits += w;
        end
        fid++;
        if (gap) idle(4);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        vec_t tbl[4];
        int   w;
        int   acc_cnt;
        int   idx;
        bit   a;

        rst = 1'b1;
        mux_select = 1'b0;
        tdata = '0;
        tkeep = '0;
        tvalid = 1'b0;
        tlast = 1'b0;
        tready0 = 1'b1;
        tready1 = 1'b1;

        tbl[0] = '{sel: 0, len: 8,  tog: 0, gap: 1, c0: 1, c1: 0};
        tbl[1] = '{sel: 1, len: 4,  tog: 0, gap: 0, c0: 1, c1: 0};
        tbl[2] = '{sel: 0, len: 3,  tog: 0, gap: 1, c0: 2, c1: 1};
        tbl[3] = '{sel: 0, len: 16, tog: 1, gap: 1, c0: 3, c1: 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tdata0", tdata0, 0);
        chk("rst_tkeep1", tkeep1, 0);
        chk("rst_tlast0", tlast0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt0", frm_cnt0, 0);
        chk("rst_cnt1", frm_cnt1, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].sel, tbl[i].len, tbl[i].tog, tbl[i].gap, 0, w);
            chk("no_bubble", w, 0);
            if (tbl[i].gap) begin
                chk("tbl_cnt0", frm_cnt0, tbl[i].c0);
                chk("tbl_cnt1", frm_cnt1, tbl[i].c1);
            end
        end

        mux_select = 1'b0;
        for (int i = 0; i < 3; i++) send_beat({fid[31:0], i[31:0]}, 8'hFF, 1'b0, 0, w);
        idle(2);
        tready0 = 1'b0;
        acc_cnt = 0;
        idx = 3;
        for (int c = 0; c < 5; c++) begin
            tvalid = 1'b1;
            tdata = {fid[31:0], idx[31:0]};
            tkeep = 8'hFF;
            tlast = 1'b0;
            @(negedge clk);
            a = tready;
            @(posedge clk);
            #1;
            if (a) begin
                idx++;
                acc_cnt++;
            end
        end
        chk("stall_accepts", acc_cnt, 2);
        tready0 = 1'b1;
        while (idx < 8) begin
            send_beat({fid[31:0], idx[31:0]}, (idx == 7) ? 8'h0F : 8'hFF, idx == 7, 0, w);
            idx++;
        end
        fid++;
        idle(4);
        chk("stall_cnt0", frm_cnt0, 4);

        do_reset();
        for (int i = 0; i < 100; i++) send_frame(i[0], 1, 0, 0, 0, w);
        idle(4);
        chk("single_cnt0", frm_cnt0, 50);
        chk("single_cnt1", frm_cnt1, 50);

        do_reset();
        mux_select = 1'b0;
        for (int i = 0; i < 2; i++) send_beat({fid[31:0], i[31:0]}, 8'hFF, 1'b0, 0, w);
        tvalid = 1'b1;
        tdata = {fid[31:0], 32'd2};
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tvalid0", tvalid0, 0);
        chk("midrst_tvalid1", tvalid1, 0);
        chk("midrst_tready", tready, 0);
        tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        fid++;
        mux_select = 1'b1;
        send_beat({fid[31:0], 32'd0}, 8'hFF, 1'b0, 0, w);
        chk("postrst_cnt0", frm_cnt0, 0);
        chk("postrst_cnt1", frm_cnt1, 0);
        send_beat({fid[31:0], 32'd1}, 8'h0F, 1'b1, 0, w);
        fid++;
        idle(4);
        chk("postrst_done_cnt1", frm_cnt1, 1);
        chk("postrst_done_cnt0", frm_cnt0, 0);

        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++)
            send_frame($urandom_range(0, 1), $urandom_range(1, 5), $urandom_range(0, 1),
                       $urandom_range(0, 3) == 0, 1, w);
        rand_rdy = 1'b0;
        tready0 = 1'b1;
        tready1 = 1'b1;
        idle(10);
        for (int i = 0; i < 80; i++) send_frame(0, 1, 0, 0, 0, w);
        idle(4);
        chk("sat_cnt0", frm_cnt0, CMAX);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
